// File: rtl/pc_next_seq.sv
// Next-fetch-address sequencer feeding the PC's addr_in.
// Handles increment, relative branch, jump, call/return with a small return stack.
module pc_next_seq #(
  parameter int              AW         = 8,
  parameter int              DEPTH      = 4,
  parameter logic [AW-1:0]   RESET_ADDR = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    br_taken,
  input  logic [AW-1:0]           br_off,
  input  logic                    jmp,
  input  logic                    call,
  input  logic                    ret,
  input  logic [AW-1:0]           tgt_addr,
  output logic [AW-1:0]           addr_next,
  output logic [$clog2(DEPTH):0]  sp,
  output logic                    stk_empty,
  output logic                    stk_full,
  output logic                    stk_err
);

  localparam int IW = $clog2(DEPTH);
  localparam int SW = IW + 1;

  logic [AW-1:0] stack [DEPTH];
  logic [AW-1:0] addr_inc;
  logic [AW-1:0] addr_d;
  logic [SW-1:0] sp_d;
  logic          err_d;
  logic          push_en;
  logic [IW-1:0] top_idx;

  // Both sums wrap at AW bits; adding the raw offset equals adding its sign extension.
  assign addr_inc  = addr_next + AW'(1);
  assign top_idx   = sp[IW-1:0] - IW'(1);
  assign stk_empty = (sp == SW'(0));
  assign stk_full  = (sp == SW'(DEPTH));

  // Request priority: stall > ret > call > jmp > branch > increment.
  always_comb begin
    addr_d  = addr_inc;
    sp_d    = sp;
    err_d   = stk_err;
    push_en = 1'b0;
    if (stall) begin
      addr_d = addr_next;
    end else if (ret) begin
      if (!stk_empty) begin
        addr_d = stack[top_idx];
        sp_d   = sp - SW'(1);
      end else begin
        err_d  = 1'b1;
      end
    end else if (call) begin
      addr_d = tgt_addr;
      if (!stk_full) begin
        push_en = 1'b1;
        sp_d    = sp + SW'(1);
      end else begin
        err_d   = 1'b1;
      end
    end else if (jmp) begin
      addr_d = tgt_addr;
    end else if (br_taken) begin
      addr_d = addr_next + br_off;
    end else begin
      addr_d = addr_inc;
    end
  end

  // State registers and return stack; reset also empties every entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_next <= RESET_ADDR;
      sp        <= {SW{1'b0}};
      stk_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack[i] <= {AW{1'b0}};
      end
    end else begin
      addr_next <= addr_d;
      sp        <= sp_d;
      stk_err   <= err_d;
      if (push_en) begin
        stack[sp[IW-1:0]] <= addr_inc;
      end else begin
        stack[sp[IW-1:0]] <= stack[sp[IW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_pc_next_seq.sv
// Self-checking bench for pc_next_seq: directed plan steps plus randomized
// traffic, compared every cycle against a queue-based reference model.
module tb_pc_next_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0;
  logic       br_taken = 1'b0;
  logic [7:0] br_off = 8'h00;
  logic       jmp = 1'b0;
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic [7:0] tgt_addr = 8'h00;
  logic [7:0] addr_next;
  logic [2:0] sp;
  logic       stk_empty;
  logic       stk_full;
  logic       stk_err;

  pc_next_seq #(.AW(8), .DEPTH(4), .RESET_ADDR(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
    .br_off(br_off), .jmp(jmp), .call(call), .ret(ret), .tgt_addr(tgt_addr),
    .addr_next(addr_next), .sp(sp), .stk_empty(stk_empty),
    .stk_full(stk_full), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain integers and a queue used as a LIFO.
  int m_addr = 0;
  int m_err  = 0;
  int m_stack[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_step();
    int off;
    if (!rst_n) begin
      m_addr = 0;
      m_err  = 0;
      m_stack.delete();
    end else if (stall) begin
      m_addr = m_addr;
    end else if (ret) begin
      if (m_stack.size() > 0) m_addr = m_stack.pop_back();
      else begin m_addr = (m_addr + 1) % 256; m_err = 1; end
    end else if (call) begin
      if (m_stack.size() < 4) m_stack.push_back((m_addr + 1) % 256);
      else m_err = 1;
      m_addr = int'(tgt_addr);
    end else if (jmp) begin
      m_addr = int'(tgt_addr);
    end else if (br_taken) begin
      off = (br_off >= 8'd128) ? int'(br_off) - 256 : int'(br_off);
      m_addr = (m_addr + off + 256) % 256;
    end else begin
      m_addr = (m_addr + 1) % 256;
    end
  endtask

  task automatic check_all();
    chk("addr_next", int'(addr_next), m_addr);
    chk("sp", int'(sp), m_stack.size());
    chk("stk_empty", int'(stk_empty), (m_stack.size() == 0) ? 1 : 0);
    chk("stk_full", int'(stk_full), (m_stack.size() == 4) ? 1 : 0);
    chk("stk_err", int'(stk_err), m_err);
  endtask

  // One clock: inputs are already stable; sample 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_in();
    rst_n = 1'b1; stall = 1'b0; br_taken = 1'b0; br_off = 8'h00;
    jmp = 1'b0; call = 1'b0; ret = 1'b0; tgt_addr = 8'h00;
  endtask

  task automatic go_to(input logic [7:0] a);
    idle_in(); jmp = 1'b1; tgt_addr = a; cyc(); idle_in();
  endtask

  logic [7:0] pushed [5];

  initial begin
    // Reset, then five idle clocks.
    rst_n = 1'b0;
    cyc();
    chk("reset_addr", int'(addr_next), 0);
    chk("reset_empty", int'(stk_empty), 1);
    idle_in();
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("idle_count", int'(addr_next), i);
    end

    // Free-run from reset through the 8'hFF -> 8'h00 wrap.
    rst_n = 1'b0; cyc(); idle_in();
    for (int i = 0; i < 254; i++) cyc();
    chk("run_fe", int'(addr_next), 8'hFE);
    cyc(); chk("wrap_ff", int'(addr_next), 8'hFF);
    cyc(); chk("wrap_00", int'(addr_next), 8'h00);
    chk("wrap_noerr", int'(stk_err), 0);

    // Relative branches, backward and forward-with-wrap.
    go_to(8'h10);
    br_taken = 1'b1; br_off = 8'hF8; cyc(); idle_in();
    chk("br_back", int'(addr_next), 8'h08);
    go_to(8'hF0);
    br_taken = 1'b1; br_off = 8'h7F; cyc(); idle_in();
    chk("br_wrap", int'(addr_next), 8'h6F);

    // Single call/return pair.
    go_to(8'h20);
    call = 1'b1; tgt_addr = 8'h80; cyc(); idle_in();
    chk("call_tgt", int'(addr_next), 8'h80);
    chk("call_sp", int'(sp), 1);
    ret = 1'b1; cyc(); idle_in();
    chk("ret_addr", int'(addr_next), 8'h21);
    chk("ret_sp", int'(sp), 0);

    // Overflow on the 5th call, LIFO returns, underflow on the 5th ret.
    go_to(8'h40);
    for (int i = 0; i < 5; i++) begin
      pushed[i] = addr_next + 8'h01;
      call = 1'b1; tgt_addr = 8'h50 + 8'(i * 16); cyc(); idle_in();
    end
    chk("ovf_sp", int'(sp), 4);
    chk("ovf_full", int'(stk_full), 1);
    chk("ovf_err", int'(stk_err), 1);
    for (int i = 3; i >= 0; i--) begin
      ret = 1'b1; cyc(); idle_in();
      chk("lifo_ret", int'(addr_next), int'(pushed[i]));
    end
    ret = 1'b1; cyc(); idle_in();
    chk("unf_addr", int'(addr_next), int'(pushed[0]) + 1);
    chk("unf_err", int'(stk_err), 1);

    // Stall holds everything despite call+jmp; reset during stall wins.
    go_to(8'h33);
    call = 1'b1; tgt_addr = 8'h77; cyc(); idle_in();
    stall = 1'b1; call = 1'b1; jmp = 1'b1; tgt_addr = 8'h99;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_addr", int'(addr_next), 8'h77);
      chk("stall_sp", int'(sp), 1);
    end
    rst_n = 1'b0; cyc(); idle_in();
    chk("stall_rst_addr", int'(addr_next), 0);
    chk("stall_rst_sp", int'(sp), 0);
    chk("stall_rst_err", int'(stk_err), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst_n    = ($urandom_range(0, 79) != 0);
      stall    = ($urandom_range(0, 7) == 0);
      ret      = ($urandom_range(0, 4) == 0);
      call     = ($urandom_range(0, 3) == 0);
      jmp      = ($urandom_range(0, 5) == 0);
      br_taken = ($urandom_range(0, 2) == 0);
      br_off   = 8'($urandom());
      tgt_addr = 8'($urandom());
      cyc();
    end
    idle_in();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_next_seq.md
Name: pc_next_seq

Overview:
- Next-address sequencer that sits directly upstream of the program counter register; its addr_next output drives the PC's 8-bit addr_in.
- Each clock it selects the next fetch address from: sequential increment, relative branch, absolute jump, call (push return address), or return (pop).
- Holds a small hardware return-address stack, supports stall, and flags stack misuse.

Parameters:
- AW, 8, address width in bits; the PC datapath is 8 bits.
- DEPTH, 4, return-stack entries (power of two, 2..8).
- RESET_ADDR, 8'h00, value loaded into addr_next on reset.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- stall  in  1  hold addr_next and stack; all requests ignored
- br_taken  in  1  relative branch request
- br_off  in  AW  signed two's-complement branch offset
- jmp  in  1  absolute jump request
- call  in  1  call request (push + jump)
- ret  in  1  return request (pop)
- tgt_addr  in  AW  target for jmp and call
- addr_next  out  AW  registered next address, drives PC addr_in
- sp  out  log2(DEPTH)+1  current stack occupancy, 0..DEPTH
- stk_empty  out  1  sp==0
- stk_full  out  1  sp==DEPTH
- stk_err  out  1  sticky overflow/underflow flag

Behaviour:
- One clock, synchronous active-low reset (rst_n sampled on the rising edge of clk); no asynchronous paths.
- Reset (rst_n=0 at the edge):
  - addr_next=RESET_ADDR, sp=0, stk_err=0.
  - All stack entries cleared to 0.
  - Reset overrides every request in the same cycle.
- Let A be the current addr_next. The registered update at each edge follows this priority (highest first):
  1. stall=1: A, sp, stack and stk_err all hold.
  2. ret=1:
     - sp>0: addr_next=stack[sp-1], sp=sp-1.
     - sp==0 (underflow): addr_next=A+1, sp stays 0, stk_err<=1.
  3. call=1:
     - sp<DEPTH: stack[sp]=A+1, sp=sp+1, addr_next=tgt_addr.
     - sp==DEPTH (overflow): push dropped, stack unchanged, addr_next=tgt_addr, stk_err<=1.
  4. jmp=1: addr_next=tgt_addr.
  5. br_taken=1: addr_next=A + sign_extend(br_off), modulo 2^AW.
  6. otherwise: addr_next=A+1, modulo 2^AW (8'hFF -> 8'h00).
- Simultaneous requests: only the highest-priority request acts; lower ones are discarded with no side effects (e.g. ret+call pops only).
- Arithmetic: all address sums are truncated to AW bits with no carry out; the pushed return address also wraps (A=8'hFF pushes 8'h00).
- Latency: a request sampled at edge N appears on addr_next after edge N; the PC sees it combinationally through addr_in.
- stk_err is sticky; only reset clears it.
- stk_empty/stk_full are combinational decodes of registered sp.
- Reset during stall or mid call/return sequence: reset wins; the stack is emptied.

Test Plan:
- Reset then 5 idle clocks -> addr_next 00,01,02,03,04,05; sp=0, stk_empty=1, stk_err=0.
- Free-run from reset to 8'hFE for 2 clocks -> 8'hFF then 8'h00, no error.
- At A=8'h10: br_off=8'hF8 -> 8'h08; then br_off=8'h7F at A=8'hF0 -> 8'h6F (wrap).
- At A=8'h20: call tgt=8'h80 -> addr_next=8'h80, sp=1; next cycle ret -> addr_next=8'h21, sp=0.
- 5 consecutive calls (DEPTH=4) -> sp stops at 4, stk_full=1, stk_err=1 on the 5th; 4 rets return the pushed addresses in LIFO order; a 5th ret gives A+1 with stk_err still 1.
- stall=1 with call+jmp asserted for 3 clocks -> addr_next and sp unchanged; assert rst_n=0 while stall=1 -> addr_next=00, sp=0, stk_err=0 after the edge.
